// File: rtl/cp_alloc_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cp_alloc_ctrl_pkg                                                          |
// | Shared types and sizing for the rename-stage checkpoint allocator.         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package cp_alloc_ctrl_pkg;

    localparam int RAT_CP_SIZE       = 8;
    localparam int RAT_CP_INDEX_SIZE = 3;
    localparam int RENAME_WIDTH      = 4;
    localparam int RECOVER_CYCLES    = 2;

    typedef logic [RAT_CP_INDEX_SIZE-1:0] cp_index_t;

    typedef enum logic [0:0] {
        CP_RUN     = 1'b0,
        CP_RECOVER = 1'b1
    } cp_state_t;

endpackage : cp_alloc_ctrl_pkg
`default_nettype wire

// File: rtl/cp_alloc_ctrl_prefix_alloc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cp_prefix_alloc                                                            |
// | Per-slot exclusive prefix count of a flag vector, plus its total.          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module cp_prefix_alloc #(
    parameter int WIDTH = 4,
    parameter int IDX_W = 3,
    parameter int CNT_W = 4
) (
    input  logic [WIDTH-1:0]            vec_i,
    output logic [WIDTH-1:0][IDX_W-1:0] offset_o,
    output logic [CNT_W-1:0]            total_o
);

    always_comb begin
        logic [CNT_W-1:0] acc;
        acc      = '0;
        offset_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            offset_o[i] = acc[IDX_W-1:0];
            acc         = acc + CNT_W'(vec_i[i]);
        end
        total_o = acc;
    end

endmodule : cp_prefix_alloc
`default_nettype wire

// File: rtl/cp_alloc_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cp_alloc_ctrl                                                              |
// | Circular branch-checkpoint slot scheduler: whole-group admission,          |
// | in-order retire, and mispredict squash with a restore lockout.             |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module cp_alloc_ctrl #(
    parameter int RENAME_WIDTH   = cp_alloc_ctrl_pkg::RENAME_WIDTH,
    parameter int CP_SIZE        = cp_alloc_ctrl_pkg::RAT_CP_SIZE,
    parameter int CP_INDEX_SIZE  = cp_alloc_ctrl_pkg::RAT_CP_INDEX_SIZE,
    parameter int RECOVER_CYCLES = cp_alloc_ctrl_pkg::RECOVER_CYCLES
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  in_valid,
    input  logic [RENAME_WIDTH-1:0]               in_is_br,
    output logic                                  in_ready,
    output logic [RENAME_WIDTH-1:0]               alloc_flag,
    output logic [RENAME_WIDTH*CP_INDEX_SIZE-1:0] alloc_idx,
    input  logic [RENAME_WIDTH-1:0]               retire_valid,
    input  logic [RENAME_WIDTH*CP_INDEX_SIZE-1:0] retire_idx,
    input  logic                                  recover,
    input  logic [CP_INDEX_SIZE-1:0]              recover_idx,
    output logic                                  restore_busy,
    output logic [CP_INDEX_SIZE:0]                cp_count,
    output logic                                  cp_full,
    output logic                                  retire_err
);
    import cp_alloc_ctrl_pkg::*;

    localparam int CNT_W  = CP_INDEX_SIZE + 1;
    localparam int FREE_W = CNT_W + 1;
    localparam int RC_W   = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;

    typedef logic [CP_INDEX_SIZE-1:0] idx_t;

    cp_state_t                           state_q, state_d;
    idx_t                                head_q, head_d;
    logic [CNT_W-1:0]                    count_q, count_d;
    logic [RC_W-1:0]                     rcnt_q, rcnt_d;
    logic                                err_q, err_d;

    logic [RENAME_WIDTH-1:0][CP_INDEX_SIZE-1:0] br_off, ret_off;
    logic [CNT_W-1:0]                    nbr, nret, nret_eff;
    logic [FREE_W-1:0]                   free_slots;
    logic                                ret_ok, retire_bad, fire;
    idx_t                                tail;

    cp_prefix_alloc #(.WIDTH(RENAME_WIDTH), .IDX_W(CP_INDEX_SIZE), .CNT_W(CNT_W)) u_br_prefix (
        .vec_i    (in_is_br),
        .offset_o (br_off),
        .total_o  (nbr)
    );

    cp_prefix_alloc #(.WIDTH(RENAME_WIDTH), .IDX_W(CP_INDEX_SIZE), .CNT_W(CNT_W)) u_ret_prefix (
        .vec_i    (retire_valid),
        .offset_o (ret_off),
        .total_o  (nret)
    );

    // The k-th retiring slot must name head+k; more retires than live entries are clipped.
    always_comb begin
        ret_ok = 1'b1;
        for (int i = 0; i < RENAME_WIDTH; i++) begin
            if (retire_valid[i] &&
                (retire_idx[i*CP_INDEX_SIZE +: CP_INDEX_SIZE] != idx_t'(head_q + ret_off[i])))
                ret_ok = 1'b0;
        end
        retire_bad = ~ret_ok | (nret > count_q);
        nret_eff   = (nret > count_q) ? count_q : nret;
    end

    always_comb begin
        free_slots = FREE_W'(CP_SIZE) - FREE_W'(count_q) + FREE_W'(nret_eff);
        in_ready   = (state_q == CP_RUN) && !recover && (FREE_W'(nbr) <= free_slots);
        fire       = in_valid & in_ready;
        tail       = head_q + idx_t'(count_q);
        alloc_flag = '0;
        alloc_idx  = '0;
        for (int i = 0; i < RENAME_WIDTH; i++) begin
            if (fire && in_is_br[i]) begin
                alloc_flag[i]                                   = 1'b1;
                alloc_idx[i*CP_INDEX_SIZE +: CP_INDEX_SIZE]     = idx_t'(tail + br_off[i]);
            end
        end
    end

    // Recover truncates the table to the restored entry, measured from the post-retire head.
    always_comb begin
        head_d  = head_q + idx_t'(nret_eff);
        count_d = count_q - nret_eff + (fire ? nbr : '0);
        state_d = state_q;
        rcnt_d  = rcnt_q;
        err_d   = err_q | retire_bad;
        if (recover) begin
            count_d = CNT_W'(idx_t'(recover_idx - head_d)) + CNT_W'(1);
            state_d = CP_RECOVER;
            rcnt_d  = RC_W'(RECOVER_CYCLES - 1);
        end else if (state_q == CP_RECOVER) begin
            if (rcnt_q == '0)
                state_d = CP_RUN;
            else
                rcnt_d = rcnt_q - RC_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= CP_RUN;
            head_q  <= '0;
            count_q <= '0;
            rcnt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            count_q <= count_d;
            rcnt_q  <= rcnt_d;
            err_q   <= err_d;
        end
    end

    assign restore_busy = (state_q == CP_RECOVER);
    assign cp_count     = count_q;
    assign cp_full      = (count_q == CNT_W'(CP_SIZE));
    assign retire_err   = err_q;

endmodule : cp_alloc_ctrl
`default_nettype wire

// File: tb/tb_cp_alloc_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_cp_alloc_ctrl                                                           |
// | Scoreboard bench for the checkpoint allocator against a behavioural model. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_cp_alloc_ctrl;

    logic        clock, reset, in_valid, in_ready, recover;
    logic [3:0]  in_is_br, alloc_flag, retire_valid, cp_count;
    logic [11:0] alloc_idx, retire_idx;
    logic [2:0]  recover_idx;
    logic        restore_busy, cp_full, retire_err;

    cp_alloc_ctrl dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_is_br     (in_is_br),
        .in_ready     (in_ready),
        .alloc_flag   (alloc_flag),
        .alloc_idx    (alloc_idx),
        .retire_valid (retire_valid),
        .retire_idx   (retire_idx),
        .recover      (recover),
        .recover_idx  (recover_idx),
        .restore_busy (restore_busy),
        .cp_count     (cp_count),
        .cp_full      (cp_full),
        .retire_err   (retire_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic        ready;
        logic [3:0]  flag;
        logic [11:0] idx;
        logic [3:0]  cnt;
        logic        full;
        logic        busy;
        logic        err;
    } snap_t;

    snap_t exp_q[$];
    snap_t obs_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    // Behavioural model state
    int m_head, m_cnt, m_rcnt;
    bit m_busy, m_err;

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; in_is_br = '0; retire_valid = '0;
        retire_idx = '0; recover = 1'b0; recover_idx = '0;
        @(posedge clock); #1;
        reset = 1'b0;
        m_head = 0; m_cnt = 0; m_rcnt = 0; m_busy = 0; m_err = 0;
    endtask

    // One clock of stimulus: expected snapshot pushed on drive, observed one captured mid-cycle.
    task automatic step(input logic v, input logic [3:0] br, input logic [3:0] rv,
                        input logic [11:0] ridx, input logic rec, input logic [2:0] rri);
        snap_t e, o;
        int    nbr, nret, k;
        bit    err_now, fire;
        in_valid = v; in_is_br = br; retire_valid = rv; retire_idx = ridx;
        recover = rec; recover_idx = rri;
        nbr = $countones(br); err_now = 0; k = 0;
        for (int i = 0; i < 4; i++) begin
            if (rv[i]) begin
                if (k >= m_cnt || int'(ridx[i*3 +: 3]) != (m_head + k) % 8) err_now = 1;
                k++;
            end
        end
        nret = (k > m_cnt) ? m_cnt : k;
        e = '0;
        e.ready = !m_busy && !rec && (nbr <= 8 - m_cnt + nret);
        fire = v && e.ready;
        k = 0;
        for (int i = 0; i < 4; i++) begin
            if (fire && br[i]) begin
                e.flag[i] = 1'b1;
                e.idx[i*3 +: 3] = 3'((m_head + m_cnt + k) % 8);
                k++;
            end
        end
        e.cnt = 4'(m_cnt); e.full = (m_cnt == 8); e.busy = m_busy; e.err = m_err;
        exp_q.push_back(e);
        @(negedge clock);
        o.ready = in_ready; o.flag = alloc_flag; o.idx = alloc_idx; o.cnt = cp_count;
        o.full = cp_full; o.busy = restore_busy; o.err = retire_err;
        obs_q.push_back(o);
        m_head = (m_head + nret) % 8;
        m_cnt  = m_cnt - nret + (fire ? nbr : 0);
        if (rec) begin
            m_cnt = ((int'(rri) - m_head + 8) % 8) + 1;
            m_busy = 1; m_rcnt = 1;
        end else if (m_busy) begin
            if (m_rcnt == 0) m_busy = 0; else m_rcnt--;
        end
        m_err = m_err | err_now;
        @(posedge clock); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'b0, 4'b0, 12'b0, 1'b0, 3'b0);
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clock);
        n_checks += 6;
        if (in_ready !== 1'b1)     begin n_fail++; $display("FAIL reset_ready: actual=%b required=1", in_ready); end
        if (alloc_flag !== 4'b0)   begin n_fail++; $display("FAIL reset_flag: actual=%b required=0000", alloc_flag); end
        if (cp_count !== 4'd0)     begin n_fail++; $display("FAIL reset_count: actual=%0d required=0", cp_count); end
        if (cp_full !== 1'b0)      begin n_fail++; $display("FAIL reset_full: actual=%b required=0", cp_full); end
        if (restore_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: actual=%b required=0", restore_busy); end
        if (retire_err !== 1'b0)   begin n_fail++; $display("FAIL reset_err: actual=%b required=0", retire_err); end
        @(posedge clock); #1;
    endtask

    task automatic test_basic_alloc();
        snap_t e, o;
        do_reset();
        step(1'b1, 4'b0101, 4'b0, 12'b0, 1'b0, 3'b0);
        idle(1);
        n_checks += 3;
        if (obs_q[0].idx[2:0] !== 3'd0) begin n_fail++; $display("FAIL basic_slot0: actual=%0d required=0", obs_q[0].idx[2:0]); end
        if (obs_q[0].idx[8:6] !== 3'd1) begin n_fail++; $display("FAIL basic_slot2: actual=%0d required=1", obs_q[0].idx[8:6]); end
        if (obs_q[1].cnt !== 4'd2)      begin n_fail++; $display("FAIL basic_count: actual=%0d required=2", obs_q[1].cnt); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL basic_alloc: actual=%h required=%h", o, e); end
        end
    endtask

    task automatic test_full_wrap();
        snap_t e, o;
        do_reset();
        step(1'b1, 4'b1111, 4'b0, 12'b0, 1'b0, 3'b0);
        step(1'b1, 4'b0111, 4'b0, 12'b0, 1'b0, 3'b0);
        step(1'b1, 4'b0011, 4'b0, 12'b0, 1'b0, 3'b0);
        step(1'b1, 4'b0011, 4'b0001, {3'd0, 3'd0, 3'd0, 3'd0}, 1'b0, 3'b0);
        idle(1);
        step(1'b1, 4'b0001, 4'b0, 12'b0, 1'b0, 3'b0);
        step(1'b1, 4'b0001, 4'b0011, {3'd0, 3'd0, 3'd2, 3'd1}, 1'b0, 3'b0);
        idle(1);
        n_checks += 4;
        if (obs_q[2].ready !== 1'b0)   begin n_fail++; $display("FAIL full_block: actual=%b required=0", obs_q[2].ready); end
        if (obs_q[3].idx[5:0] !== {3'd0, 3'd7}) begin n_fail++; $display("FAIL full_wrap_idx: actual=%h required=07", obs_q[3].idx[5:0]); end
        if (obs_q[4].full !== 1'b1)    begin n_fail++; $display("FAIL full_flag: actual=%b required=1", obs_q[4].full); end
        if (obs_q[6].idx[2:0] !== 3'd1) begin n_fail++; $display("FAIL full_refill: actual=%0d required=1", obs_q[6].idx[2:0]); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL full_wrap: actual=%h required=%h", o, e); end
        end
    endtask

    task automatic test_recover();
        snap_t e, o;
        do_reset();
        step(1'b1, 4'b1111, 4'b0, 12'b0, 1'b0, 3'b0);
        step(1'b1, 4'b1111, 4'b1111, {3'd3, 3'd2, 3'd1, 3'd0}, 1'b0, 3'b0);
        step(1'b1, 4'b0111, 4'b0011, {3'd0, 3'd0, 3'd5, 3'd4}, 1'b0, 3'b0);
        step(1'b0, 4'b0, 4'b0, 12'b0, 1'b1, 3'd0);
        step(1'b1, 4'b0001, 4'b0, 12'b0, 1'b0, 3'b0);
        step(1'b1, 4'b0001, 4'b0, 12'b0, 1'b0, 3'b0);
        step(1'b1, 4'b0001, 4'b0, 12'b0, 1'b0, 3'b0);
        idle(1);
        n_checks += 5;
        if (obs_q[3].cnt !== 4'd5)      begin n_fail++; $display("FAIL rec_pre_count: actual=%0d required=5", obs_q[3].cnt); end
        if (obs_q[4].cnt !== 4'd3)      begin n_fail++; $display("FAIL rec_count: actual=%0d required=3", obs_q[4].cnt); end
        if (obs_q[5].busy !== 1'b1 || obs_q[5].ready !== 1'b0)
            begin n_fail++; $display("FAIL rec_lockout: actual busy=%b ready=%b required busy=1 ready=0", obs_q[5].busy, obs_q[5].ready); end
        if (obs_q[6].busy !== 1'b0)     begin n_fail++; $display("FAIL rec_exit: actual=%b required=0", obs_q[6].busy); end
        if (obs_q[6].idx[2:0] !== 3'd1) begin n_fail++; $display("FAIL rec_next_idx: actual=%0d required=1", obs_q[6].idx[2:0]); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL recover: actual=%h required=%h", o, e); end
        end
    endtask

    task automatic test_recover_simul();
        snap_t e, o;
        do_reset();
        step(1'b1, 4'b1111, 4'b0, 12'b0, 1'b0, 3'b0);
        step(1'b1, 4'b0011, 4'b0001, {3'd0, 3'd0, 3'd0, 3'd0}, 1'b1, 3'd2);
        idle(3);
        n_checks += 2;
        if (obs_q[1].flag !== 4'b0) begin n_fail++; $display("FAIL simul_flag: actual=%b required=0000", obs_q[1].flag); end
        if (obs_q[2].cnt !== 4'd2)  begin n_fail++; $display("FAIL simul_count: actual=%0d required=2", obs_q[2].cnt); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL recover_simul: actual=%h required=%h", o, e); end
        end
    endtask

    task automatic test_retire_err();
        snap_t e, o;
        do_reset();
        step(1'b1, 4'b0011, 4'b0, 12'b0, 1'b0, 3'b0);
        step(1'b0, 4'b0, 4'b0001, {3'd0, 3'd0, 3'd0, 3'd1}, 1'b0, 3'b0);
        idle(3);
        n_checks += 2;
        if (obs_q[2].err !== 1'b1) begin n_fail++; $display("FAIL err_set: actual=%b required=1", obs_q[2].err); end
        if (obs_q[4].err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: actual=%b required=1", obs_q[4].err); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL retire_err: actual=%h required=%h", o, e); end
        end
        do_reset();
        step(1'b0, 4'b0, 4'b0001, 12'b0, 1'b0, 3'b0);
        idle(1);
        n_checks += 2;
        if (obs_q[1].err !== 1'b1) begin n_fail++; $display("FAIL err_empty: actual=%b required=1", obs_q[1].err); end
        if (obs_q[1].cnt !== 4'd0) begin n_fail++; $display("FAIL err_empty_count: actual=%0d required=0", obs_q[1].cnt); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL retire_empty: actual=%h required=%h", o, e); end
        end
    endtask

    task automatic test_reset_in_recover();
        snap_t e, o;
        do_reset();
        step(1'b1, 4'b0111, 4'b0, 12'b0, 1'b0, 3'b0);
        step(1'b0, 4'b0, 4'b0, 12'b0, 1'b1, 3'd1);
        idle(1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL pre_reset_recover: actual=%h required=%h", o, e); end
        end
        do_reset();
        step(1'b1, 4'b0001, 4'b0, 12'b0, 1'b0, 3'b0);
        n_checks += 3;
        if (obs_q[0].ready !== 1'b1) begin n_fail++; $display("FAIL rst_rec_ready: actual=%b required=1", obs_q[0].ready); end
        if (obs_q[0].cnt !== 4'd0)   begin n_fail++; $display("FAIL rst_rec_count: actual=%0d required=0", obs_q[0].cnt); end
        if (obs_q[0].busy !== 1'b0)  begin n_fail++; $display("FAIL rst_rec_busy: actual=%b required=0", obs_q[0].busy); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL reset_in_recover: actual=%h required=%h", o, e); end
        end
    endtask

    task automatic test_back_to_back();
        snap_t e, o;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            logic [3:0]  br, rv;
            logic [11:0] ridx;
            logic        rec, v;
            logic [2:0]  rri;
            int          k, left;
            br = 4'($urandom);
            rv = 4'($urandom);
            while ($countones(rv) > m_cnt) rv = rv & (rv - 4'd1);
            ridx = 12'($urandom);
            k = 0;
            for (int i = 0; i < 4; i++) begin
                if (rv[i]) begin
                    ridx[i*3 +: 3] = 3'((m_head + k) % 8);
                    k++;
                end
            end
            left = m_cnt - k;
            rec  = (left > 0) && ($urandom_range(0, 9) == 0);
            rri  = rec ? 3'((m_head + k + int'($urandom_range(0, left - 1))) % 8) : 3'($urandom);
            v    = ($urandom_range(0, 3) != 0);
            step(v, br, rv, ridx, rec, rri);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL back_to_back: actual=%h required=%h", o, e); end
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_is_br = '0; retire_valid = '0;
        retire_idx = '0; recover = 1'b0; recover_idx = '0;
        repeat (2) @(posedge clock);
        #1;
        test_reset();
        test_basic_alloc();
        test_full_wrap();
        test_recover();
        test_recover_simul();
        test_retire_err();
        test_reset_in_recover();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_cp_alloc_ctrl
`default_nettype wire

// File: doc/cp_alloc_ctrl.md
Name: cp_alloc_ctrl

Overview:
- Checkpoint-slot scheduler for the rename stage's branch checkpoint table (circular, CP_SIZE entries).
- Each rename group is admitted whole or not at all; admitted branches get consecutive checkpoint indices in program order.
- Slots are freed in order when branches retire; on a mispredict, all slots younger than the recovered one are squashed.
- Drives `check`/`check_idx`/`check_flag` toward the mapping table and the stall/allocatable signals toward decode.

Parameters:
- RENAME_WIDTH, 4, uops per rename group and retire slots per cycle.
- CP_SIZE, 8, number of checkpoint entries; must be a power of two.
- CP_INDEX_SIZE, 3, log2(CP_SIZE).
- RECOVER_CYCLES, 2, lockout cycles after a recover, covering the mapping-table restore.

Ports:
- clock  in  1  single clock.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  rename group present.
- in_is_br  in  RENAME_WIDTH  per-slot "uop is a branch" (br_type != BR_X).
- in_ready  out  1  group accepted this cycle when in_valid is high.
- alloc_flag  out  RENAME_WIDTH  per-slot checkpoint allocated; equals in_is_br when the group fires, else 0.
- alloc_idx  out  RENAME_WIDTH*CP_INDEX_SIZE  per-slot assigned index; 0 where alloc_flag=0.
- retire_valid  in  RENAME_WIDTH  per-slot retiring branch.
- retire_idx  in  RENAME_WIDTH*CP_INDEX_SIZE  index of each retiring branch.
- recover  in  1  mispredict restore request.
- recover_idx  in  CP_INDEX_SIZE  checkpoint being restored; it is kept live.
- restore_busy  out  1  high while in the RECOVER state.
- cp_count  out  CP_INDEX_SIZE+1  live checkpoints.
- cp_full  out  1  cp_count == CP_SIZE.
- retire_err  out  1  sticky; set on an out-of-order retire.

Behaviour:
- State:
  - head: oldest live index.
  - count: number of live checkpoints.
  - fsm ∈ {RUN, RECOVER}.
  - rcnt: recover lockout counter.
- Reset values: head=0, count=0, fsm=RUN, rcnt=0, retire_err=0. Outputs after reset: in_ready=1, alloc_flag=0, cp_count=0, cp_full=0, restore_busy=0.
- Admission (combinational from current state):
  - nbr = popcount(in_is_br).
  - free = CP_SIZE − count + nret, where nret = number of retires this cycle. Same-cycle retires free slots.
  - in_ready = (fsm==RUN) & ~recover & (nbr <= free).
  - A group with nbr=0 is always ready in RUN.
- Allocation when in_valid & in_ready:
  - The k-th branch slot (ascending slot order) gets index (head + count + k) mod CP_SIZE, with head/count pre-retire.
  - count += nbr.
  - No partial groups: in_ready=0 means no slot gets alloc_flag.
- Retire:
  - retire_valid slots must form a prefix-free, in-order sequence: the k-th valid slot's retire_idx must equal (head + k) mod CP_SIZE.
  - head += nret, count −= nret.
  - Any mismatch sets retire_err; the state update still applies nret.
  - A retire with count=0 also sets retire_err and is ignored.
- Recover (highest priority):
  - Compute the new count as ((recover_idx − head') mod CP_SIZE) + 1, where head' is head after the same-cycle retire.
  - Any allocation that cycle is blocked (in_ready=0).
  - fsm→RECOVER, rcnt=RECOVER_CYCLES−1.
- RECOVER state:
  - restore_busy=1, in_ready=0. Retires are still processed.
  - rcnt decrements each cycle; at 0, return to RUN next cycle.
  - A new recover while in RECOVER recomputes count and reloads rcnt.
- Arithmetic:
  - All index math is modulo CP_SIZE (natural wrap of CP_INDEX_SIZE bits).
  - count is CP_INDEX_SIZE+1 bits and never exceeds CP_SIZE.
- Simultaneous events:
  - Retire and allocate in the same cycle are both applied.
  - Recover beats allocate.
  - Reset beats everything, including mid-RECOVER: return to RUN with an empty table.
- Latency: 0-cycle grant (combinational); state is visible on the next edge.

Decomposition:
- Shared package (micro_op.svh):
  - cp_index_t.
  - RAT_CP_SIZE and RAT_CP_INDEX_SIZE (feed CP_SIZE/CP_INDEX_SIZE).
  - RENAME_WIDTH.
  - enum cp_state_t {CP_RUN, CP_RECOVER}.
- One natural sub-module: cp_prefix_alloc. Combinational prefix-count over in_is_br producing per-slot offsets k and nbr; reused for the retire ordering check.

Test Plan:
- Reset, then a group with in_is_br=4'b0101, in_valid=1 → in_ready=1, alloc_idx slot0=0, slot2=1; next cycle cp_count=2.
- Fill to 7 live, then a group with 2 branches → in_ready=0, alloc_flag=0. Same again with retire_valid=1, retire_idx=head → in_ready=1, indices wrap (7, 0).
- head=6, count=5 (live 6,7,0,1,2), recover with recover_idx=0 → cp_count=3 next cycle. restore_busy=1 for 2 cycles, in_ready=0 throughout, and the next allocation gets index 1.
- recover and in_valid with branches in the same cycle → no alloc_flag. A retire in that same cycle updates head before the count computation.
- retire_idx ≠ head → retire_err=1 and stays 1 until reset. A retire with count=0 → retire_err=1, count stays 0.
- Assert reset during RECOVER → next cycle in_ready=1, cp_count=0, restore_busy=0.
